// File: rtl/shim_abs_sample_framer.sv
// Collects eight per-channel signed samples in order, stores their saturated magnitudes,
// and commits all eight atomically as one 120-bit frame; a missing or out-of-order sample raises a sticky error.
module shim_abs_sample_framer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         enable,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [2:0]   s_channel,
    input  logic [15:0]  s_data,
    output logic [119:0] abs_sample_concat,
    output logic         frame_strobe,
    output logic         sample_core_done,
    output logic         err_sequence,
    output logic         err_timeout,
    output logic [31:0]  frame_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, ERROR} state_t;

    state_t          state;
    logic [2:0]      exp_ch;
    logic [6:0][14:0] staging;
    logic [TW-1:0]   tcnt;
    logic            t_active;

    logic [15:0] neg_data;
    logic [14:0] abs_val;
    logic        accept, in_order, commit, timeout;

    // -32768 has no 15-bit magnitude, so it saturates to 32767
    always_comb begin
        neg_data = ~s_data + 16'd1;
        abs_val  = s_data[14:0];
        if (s_data[15])
            abs_val = (s_data == 16'h8000) ? 15'h7fff : neg_data[14:0];
    end

    assign s_ready  = resetn && (state == COLLECT) && enable;
    assign accept   = s_valid && s_ready;
    assign in_order = (s_channel == exp_ch);
    assign commit   = accept && in_order && (exp_ch == 3'd7);
    // the edge that would make the count reach TIMEOUT_CYCLES; a commit there wins
    assign timeout  = t_active && (tcnt == TLAST) && !commit;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= IDLE;
            exp_ch            <= 3'd0;
            staging           <= '0;
            tcnt              <= '0;
            t_active          <= 1'b0;
            abs_sample_concat <= '0;
            frame_strobe      <= 1'b0;
            sample_core_done  <= 1'b0;
            err_sequence      <= 1'b0;
            err_timeout       <= 1'b0;
            frame_count       <= '0;
        end else begin
            frame_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state  <= COLLECT;
                        exp_ch <= 3'd0;
                    end
                end
                COLLECT: begin
                    if (!enable) begin
                        state    <= IDLE;
                        exp_ch   <= 3'd0;
                        t_active <= 1'b0;
                    end else begin
                        if (t_active && tcnt != TMAX)
                            tcnt <= tcnt + 1'b1;
                        if (accept && in_order) begin
                            if (commit) begin
                                abs_sample_concat <= {abs_val, staging};
                                frame_strobe      <= 1'b1;
                                frame_count       <= frame_count + 32'd1;
                                sample_core_done  <= 1'b1;
                                exp_ch            <= 3'd0;
                                t_active          <= 1'b0;
                            end else begin
                                staging[s_channel] <= abs_val;
                                exp_ch             <= exp_ch + 3'd1;
                            end
                            if (s_channel == 3'd0) begin
                                tcnt     <= '0;
                                t_active <= 1'b1;
                            end
                        end
                        if (accept && !in_order)
                            err_sequence <= 1'b1;
                        if (timeout)
                            err_timeout <= 1'b1;
                        if ((accept && !in_order) || timeout)
                            state <= ERROR;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shim_abs_sample_framer.sv
// Randomized and directed bench for shim_abs_sample_framer: a frame-level reference model
// predicts commits into a scoreboard that a negedge monitor drains on each frame_strobe.
module tb_shim_abs_sample_framer;
    localparam int T = 16;
    localparam int M_IDLE = 0, M_COL = 1, M_ERR = 2;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         enable = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [2:0]   s_channel = 3'd0;
    logic [15:0]  s_data = 16'd0;
    logic [119:0] abs_sample_concat;
    logic         frame_strobe, sample_core_done, err_sequence, err_timeout;
    logic [31:0]  frame_count;

    shim_abs_sample_framer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_channel(s_channel), .s_data(s_data), .abs_sample_concat(abs_sample_concat),
        .frame_strobe(frame_strobe), .sample_core_done(sample_core_done),
        .err_sequence(err_sequence), .err_timeout(err_timeout), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [119:0] q_concat[$];
    logic [31:0]  q_count[$];

    // frame-level reference model
    int           mst, mexp, now, t0;
    int           vals[8];
    logic [119:0] mconcat;
    logic [31:0]  mcount;
    bit           mdone, meseq, meto, mstrobe, mopen;

    function automatic int absv(logic [15:0] d);
        int x = int'($signed(d));
        if (x < 0) x = -x;
        if (x > 32767) x = 32767;
        return x;
    endfunction

    task automatic chk(string n, logic [127:0] a, logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic post_checks();
        chk("frame_strobe", frame_strobe, mstrobe);
        chk("frame_count", frame_count, mcount);
        chk("sample_core_done", sample_core_done, mdone);
        chk("err_sequence", err_sequence, meseq);
        chk("err_timeout", err_timeout, meto);
        chk("abs_sample_concat", abs_sample_concat, mconcat);
    endtask

    task automatic model_reset();
        mst = M_IDLE; mexp = 0; mopen = 0; t0 = 0;
        foreach (vals[i]) vals[i] = 0;
        mconcat = '0; mcount = '0;
        mdone = 0; meseq = 0; meto = 0; mstrobe = 0;
    endtask

    task automatic cyc(bit en, bit v, logic [2:0] ch, logic [15:0] d);
        bit com, seqe, to;
        enable = en; s_valid = v; s_channel = ch; s_data = d;
        #1 chk("s_ready", s_ready, (mst == M_COL) && en);
        @(posedge clk);
        mstrobe = 0;
        if (mst == M_IDLE) begin
            if (en) begin mst = M_COL; mexp = 0; end
        end else if (mst == M_COL) begin
            if (!en) begin
                mst = M_IDLE; mexp = 0; mopen = 0;
            end else begin
                com = 0; seqe = 0; to = 0;
                if (v) begin
                    if (int'(ch) == mexp) begin
                        if (ch == 3'd0) begin mopen = 1; t0 = now; end
                        vals[ch] = absv(d);
                        if (ch == 3'd7) com = 1; else mexp++;
                    end else seqe = 1;
                end
                if (mopen && !com && (now - t0 == T)) to = 1;
                if (com) begin
                    for (int i = 0; i < 8; i++) mconcat[15*i +: 15] = 15'(vals[i]);
                    mcount++;
                    q_concat.push_back(mconcat);
                    q_count.push_back(mcount);
                    mdone = 1; mstrobe = 1; mexp = 0; mopen = 0;
                end
                if (seqe) meseq = 1;
                if (to) meto = 1;
                if (seqe || to) mst = M_ERR;
            end
        end
        now++;
        #1 post_checks();
    endtask

    task automatic send(logic [2:0] ch, logic [15:0] d);
        cyc(1'b1, 1'b1, ch, d);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'($urandom), 16'($urandom));
    endtask

    task automatic rst();
        resetn = 1'b0; enable = 1'($urandom); s_valid = 1'b1;
        #1 chk("s_ready_in_reset", s_ready, 1'b0);
        @(posedge clk);
        model_reset();
        now++;
        #1 post_checks();
        resetn = 1'b1;
    endtask

    function automatic logic [15:0] rand_data();
        return ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    endfunction

    task automatic rand_frame();
        int gaps = 0;
        for (int c = 0; c < 8; c++) begin
            while (gaps < 6 && $urandom_range(0, 2) == 0) begin
                cyc(1'b1, 1'b0, 3'($urandom), 16'($urandom));
                gaps++;
            end
            send(3'(c), rand_data());
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (frame_strobe) begin
            if (q_concat.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_strobe: got strobe want none");
            end else begin
                chk("sb_concat", abs_sample_concat, q_concat.pop_front());
                chk("sb_count", frame_count, q_count.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [119:0] golden;
        int g[8] = '{100, 100, 0, 32767, 32767, 1, 5, 7};
        logic [15:0] basic[8] = '{16'd100, -16'sd100, 16'd0, 16'd32767, 16'h8000, 16'hffff, 16'd5, -16'sd7};
        model_reset();
        now = 0;

        // reset state and idle with enable low
        rst(); rst();
        cyc(1'b0, 1'b1, 3'd0, 16'd1);

        // basic frame
        cyc(1'b1, 1'b0, 3'd0, 16'd0);
        for (int c = 0; c < 8; c++) send(3'(c), basic[c]);
        for (int i = 0; i < 8; i++) golden[15*i +: 15] = 15'(g[i]);
        chk("basic_concat", abs_sample_concat, golden);
        chk("basic_count", frame_count, 32'd1);

        // gaps / random frames
        for (int f = 0; f < 8; f++) rand_frame();

        // enable drop after ch3, then full new frame
        for (int c = 0; c < 4; c++) send(3'(c), rand_data());
        cyc(1'b0, 1'b0, 3'd0, 16'd0);
        cyc(1'b0, 1'b1, 3'd4, 16'd9);
        cyc(1'b1, 1'b0, 3'd0, 16'd0);
        rand_frame();
        chk("drop_no_error", {err_sequence, err_timeout}, 2'b00);

        // sequence error 0,1,3
        send(3'd0, rand_data()); send(3'd1, rand_data()); send(3'd3, rand_data());
        chk("seq_err", err_sequence, 1'b1);
        send(3'd2, 16'd3); cyc(1'b0, 1'b1, 3'd0, 16'd3); send(3'd0, 16'd4);

        // timeout at 16 cycles after ch0
        rst(); cyc(1'b1, 1'b0, 3'd0, 16'd0);
        for (int c = 0; c < 6; c++) send(3'(c), rand_data());
        idle(10);
        chk("timeout_early", err_timeout, 1'b0);
        idle(1);
        chk("timeout_hit", err_timeout, 1'b1);
        idle(2);

        // ch7 exactly on the timeout edge: commit wins
        rst(); cyc(1'b1, 1'b0, 3'd0, 16'd0);
        for (int c = 0; c < 7; c++) send(3'(c), rand_data());
        idle(9);
        send(3'd7, rand_data());
        chk("edge_commit", {frame_strobe, err_timeout}, 2'b10);
        idle(3);
        rand_frame();

        // reset mid-frame, then normal frame
        for (int c = 0; c < 5; c++) send(3'(c), rand_data());
        rst();
        chk("rst_concat", abs_sample_concat, 120'd0);
        cyc(1'b1, 1'b0, 3'd0, 16'd0);
        rand_frame();
        chk("rst_count", frame_count, 32'd1);

        repeat (2) @(posedge clk);
        #1 chk("queue_empty", q_concat.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
